sync_err_ctrl_n: RTL and testbench

Parametrised synchronization-error controller for the TMB trigger path. It takes NSRC single-cycle error strobes (bx0 sync, ALCT ECC rx/tx, bx0 match, and future sources) and latches each one for VME readout. It also keeps a saturating occurrence count per source and captures which sources fired first and the BXN at which they fired. Enabled errors drive an FSM that asserts NACT action outputs (MPC blanking, pretrigger stop, readout stop, ...). An optional auto-recovery timeout can clear those actions.

---
 rtl/sync_err_ctrl_n.sv | 143 ++++++++++++++
 tb/tb_sync_err_ctrl_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_err_ctrl_n.sv
// Synchronization-error controller: latches error strobes, counts them per source,
// captures the first enabled event and sequences action outputs with optional auto-recovery.
module sync_err_ctrl_n #(
  parameter int NSRC = 8,
  parameter int NACT = 3,
  parameter int CNTW = 8,
  parameter int BXNW = 12,
  parameter int DLYW = 16
) (
  input  logic                 clock,
  input  logic                 global_reset,
  input  logic                 ttc_resync,
  input  logic                 sync_err_reset,
  input  logic [BXNW-1:0]      bxn,
  input  logic [NSRC-1:0]      err_src,
  input  logic [NSRC-1:0]      err_src_en,
  input  logic [NACT-1:0]      act_en,
  input  logic                 auto_clr_en,
  input  logic [DLYW-1:0]      auto_clr_dly,
  output logic                 sync_err,
  output logic [NSRC-1:0]      err_ff,
  output logic [NSRC*CNTW-1:0] err_cnt,
  output logic [NSRC-1:0]      first_err_mask,
  output logic [BXNW-1:0]      first_err_bxn,
  output logic [NACT-1:0]      sync_err_act,
  output logic [1:0]           fsm_state,
  output logic [7:0]           recover_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    ACTIVE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [DLYW-1:0] dly_cnt, dly_cnt_nxt;
  logic            sync_err_nxt;
  logic [NACT-1:0] act_nxt;
  logic            capture, rec_inc;
  logic            sync_clr, sync_set;

  assign sync_clr  = ttc_resync | sync_err_reset;
  assign sync_set  = |(err_src & err_src_en);
  assign fsm_state = state;

  always_comb begin
    state_nxt    = state;
    dly_cnt_nxt  = dly_cnt;
    sync_err_nxt = sync_err;
    act_nxt      = sync_err_act;
    capture      = 1'b0;
    rec_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (sync_set) begin
          sync_err_nxt = 1'b1;
          capture      = 1'b1;
          state_nxt    = LATCHED;
        end
      end
      LATCHED: begin
        act_nxt   = act_en;
        state_nxt = ACTIVE;
      end
      ACTIVE: begin
        act_nxt = act_en;
        if (auto_clr_en && (auto_clr_dly != '0)) begin
          dly_cnt_nxt = auto_clr_dly;
          state_nxt   = RECOVER;
        end
      end
      RECOVER: begin
        act_nxt = act_en;
        if (!auto_clr_en) begin
          state_nxt = ACTIVE;
        end else if (sync_set) begin
          dly_cnt_nxt = auto_clr_dly;
        // Leave on the decrement that would bring the counter to 1, so the
        // drop lands auto_clr_dly clocks after ACTIVE was entered.
        end else if (dly_cnt <= DLYW'(2)) begin
          state_nxt    = IDLE;
          sync_err_nxt = 1'b0;
          act_nxt      = '0;
          rec_inc      = 1'b1;
        end else begin
          dly_cnt_nxt = dly_cnt - DLYW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state          <= IDLE;
      dly_cnt        <= '0;
      sync_err       <= 1'b0;
      sync_err_act   <= '0;
      first_err_mask <= '0;
      first_err_bxn  <= '0;
      recover_cnt    <= '0;
    end else if (sync_clr) begin
      state          <= IDLE;
      dly_cnt        <= '0;
      sync_err       <= 1'b0;
      sync_err_act   <= '0;
      first_err_mask <= '0;
      first_err_bxn  <= '0;
      recover_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      dly_cnt      <= dly_cnt_nxt;
      sync_err     <= sync_err_nxt;
      sync_err_act <= act_nxt;
      if (capture) begin
        first_err_mask <= err_src & err_src_en;
        first_err_bxn  <= bxn;
      end
      if (rec_inc && (recover_cnt != 8'hFF))
        recover_cnt <= recover_cnt + 8'd1;
    end
  end

  // Flags and counters ignore the enables so VME sees every raw strobe.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      err_ff  <= '0;
      err_cnt <= '0;
    end else if (sync_clr) begin
      err_ff  <= '0;
      err_cnt <= '0;
    end else begin
      err_ff <= err_ff | err_src;
      for (int i = 0; i < NSRC; i++) begin
        if (err_src[i] && (err_cnt[i*CNTW +: CNTW] != '1))
          err_cnt[i*CNTW +: CNTW] <= err_cnt[i*CNTW +: CNTW] + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_err_ctrl_n.sv
// Bench for sync_err_ctrl_n: directed scenarios plus randomized traffic, all
// outputs compared every clock against a cycle-level behavioural model.
module tb_sync_err_ctrl_n;
  localparam int NSRC = 8, NACT = 3, CNTW = 8, BXNW = 12, DLYW = 16;

  logic              clock = 1'b0;
  logic              global_reset, ttc_resync, sync_err_reset;
  logic [BXNW-1:0]   bxn;
  logic [NSRC-1:0]   err_src, err_src_en;
  logic [NACT-1:0]   act_en;
  logic              auto_clr_en;
  logic [DLYW-1:0]   auto_clr_dly;
  logic              sync_err;
  logic [NSRC-1:0]   err_ff, first_err_mask;
  logic [NSRC*CNTW-1:0] err_cnt;
  logic [BXNW-1:0]   first_err_bxn;
  logic [NACT-1:0]   sync_err_act;
  logic [1:0]        fsm_state;
  logic [7:0]        recover_cnt;

  sync_err_ctrl_n #(.NSRC(NSRC), .NACT(NACT), .CNTW(CNTW), .BXNW(BXNW), .DLYW(DLYW)) dut (
    .clock(clock), .global_reset(global_reset), .ttc_resync(ttc_resync),
    .sync_err_reset(sync_err_reset), .bxn(bxn), .err_src(err_src),
    .err_src_en(err_src_en), .act_en(act_en), .auto_clr_en(auto_clr_en),
    .auto_clr_dly(auto_clr_dly), .sync_err(sync_err), .err_ff(err_ff),
    .err_cnt(err_cnt), .first_err_mask(first_err_mask),
    .first_err_bxn(first_err_bxn), .sync_err_act(sync_err_act),
    .fsm_state(fsm_state), .recover_cnt(recover_cnt)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: event-level view (is an error pending, how long since
  // capture, is a recovery countdown running, how many quiet cycles remain).
  bit        m_err;
  int        m_age;
  bit        m_rec;
  int        m_left;
  bit [7:0]  m_ff, m_mask;
  int        m_cnt[NSRC];
  int        m_bxn;
  int        m_act;
  int        m_rcnt;

  task automatic model_clear();
    m_err = 0; m_age = 0; m_rec = 0; m_left = 0; m_ff = 0; m_mask = 0;
    m_bxn = 0; m_act = 0; m_rcnt = 0;
    for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    bit set;
    if (global_reset || ttc_resync || sync_err_reset) begin
      model_clear();
      return;
    end
    m_ff |= err_src;
    for (int i = 0; i < NSRC; i++)
      if (err_src[i] && m_cnt[i] < 255) m_cnt[i]++;
    set = ((err_src & err_src_en) != 0);
    if (!m_err) begin
      if (set) begin
        m_err = 1; m_age = 1; m_mask = err_src & err_src_en; m_bxn = bxn;
      end
    end else if (m_age == 1) begin
      m_act = act_en; m_age = 2;
    end else if (!m_rec) begin
      m_act = act_en;
      if (auto_clr_en && auto_clr_dly != 0) begin
        m_rec = 1; m_left = auto_clr_dly;
      end
    end else begin
      m_act = act_en;
      if (!auto_clr_en) m_rec = 0;
      else if (set) m_left = auto_clr_dly;
      else if (m_left - 1 <= 1) begin
        m_err = 0; m_act = 0; m_rec = 0; m_age = 0;
        if (m_rcnt < 255) m_rcnt++;
      end else m_left--;
    end
  endtask

  function automatic logic [63:0] exp_cnt();
    logic [63:0] e;
    for (int i = 0; i < NSRC; i++) e[i*CNTW +: CNTW] = 8'(m_cnt[i]);
    return e;
  endfunction

  function automatic int exp_fsm();
    if (!m_err) return 0;
    if (m_age == 1) return 1;
    return m_rec ? 3 : 2;
  endfunction

  task automatic check_all();
    check("m_sync_err", sync_err, m_err);
    check("m_err_ff", err_ff, m_ff);
    check("m_err_cnt", err_cnt, exp_cnt());
    check("m_first_mask", first_err_mask, m_mask);
    check("m_first_bxn", first_err_bxn, m_bxn);
    check("m_act", sync_err_act, m_act);
    check("m_fsm", fsm_state, exp_fsm());
    check("m_recover_cnt", recover_cnt, m_rcnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
    bxn = bxn + 1'b1;
  endtask

  task automatic do_clear();
    sync_err_reset = 1; err_src = 0;
    tick();
    sync_err_reset = 0;
  endtask

  initial begin
    int k, guard;
    logic [BXNW-1:0] b1;
    global_reset = 1; ttc_resync = 0; sync_err_reset = 0; bxn = 0;
    err_src = 0; err_src_en = 0; act_en = 0; auto_clr_en = 0; auto_clr_dly = 0;
    model_clear();
    @(posedge clock); #1;
    check("rst_sync_err", sync_err, 0);
    check("rst_fsm", fsm_state, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clock);
    global_reset = 0;

    // Single source with action timing
    err_src_en = 8'hFF; act_en = 3'b101; bxn = 12'h123; err_src = 8'h04;
    tick();
    err_src = 0;
    check("t1_err_ff", err_ff, 8'h04);
    check("t1_cnt2", err_cnt[23:16], 1);
    check("t1_sync_err", sync_err, 1);
    check("t1_bxn", first_err_bxn, 12'h123);
    tick();
    check("t1_act", sync_err_act, 3'b101);
    check("t1_fsm", fsm_state, 2);
    do_clear();
    check("clr_fsm", fsm_state, 0);

    // First-error capture ignores later sources
    b1 = bxn; err_src = 8'h09;
    tick();
    err_src = 0; tick();
    err_src = 8'h02; tick();
    err_src = 0; tick();
    check("t2_mask", first_err_mask, 8'h09);
    check("t2_err_ff", err_ff, 8'h0B);
    check("t2_bxn", first_err_bxn, b1);
    do_clear();

    // Counter saturation then VME clear
    err_src = 8'h01;
    repeat (300) tick();
    check("t3_cnt0_sat", err_cnt[7:0], 255);
    do_clear();
    check("t3_clr_sync_err", sync_err, 0);
    check("t3_clr_ff", err_ff, 0);
    check("t3_clr_cnt", err_cnt, 0);
    check("t3_clr_act", sync_err_act, 0);
    check("t3_clr_fsm", fsm_state, 0);

    // Disabled sources only flag and count
    err_src_en = 8'h00; err_src = 8'hFF;
    tick();
    err_src = 0; tick();
    check("t4_ff", err_ff, 8'hFF);
    check("t4_cnt", err_cnt, 64'h0101_0101_0101_0101);
    check("t4_sync_err", sync_err, 0);
    check("t4_act", sync_err_act, 0);
    check("t4_fsm", fsm_state, 0);
    do_clear();
    err_src_en = 8'hFF;

    // Auto-recovery after 10 quiet clocks, then with a mid-countdown error
    auto_clr_en = 1; auto_clr_dly = 16'd10; err_src = 8'h01;
    tick();
    err_src = 0;
    guard = 0;
    while (fsm_state != 2 && guard < 10) begin tick(); guard++; end
    k = 0;
    while (sync_err && k <= 40) begin tick(); k++; end
    check("t5_drop_clocks", k, 10);
    check("t5_recover_cnt", recover_cnt, 1);
    check("t5_err_ff", err_ff, 8'h01);
    err_src = 8'h01;
    tick();
    err_src = 0;
    guard = 0;
    while (fsm_state != 2 && guard < 10) begin tick(); guard++; end
    k = 0;
    while (sync_err && k <= 40) begin
      err_src = (k == 6) ? 8'h01 : 8'h00;
      tick(); k++;
    end
    err_src = 0;
    check("t5_reload_clocks", k, 16);
    check("t5_recover_cnt2", recover_cnt, 2);

    // Async reset mid-RECOVER
    err_src = 8'h10;
    tick();
    err_src = 0;
    repeat (5) tick();
    check("t6_in_recover", fsm_state, 3);
    #2 global_reset = 1;
    #1;
    model_clear();
    check("t6_async_sync_err", sync_err, 0);
    check("t6_async_act", sync_err_act, 0);
    check("t6_async_ff", err_ff, 0);
    check("t6_async_fsm", fsm_state, 0);
    @(negedge clock);
    global_reset = 0;
    ttc_resync = 1; err_src = 8'hFF;
    tick();
    ttc_resync = 0; err_src = 0;
    check("t6_resync_ff", err_ff, 0);
    check("t6_resync_cnt", err_cnt, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      err_src = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 49) == 0) err_src_en = 8'($urandom);
      act_en = 3'($urandom);
      if ($urandom_range(0, 39) == 0) auto_clr_en = ~auto_clr_en;
      if ($urandom_range(0, 29) == 0) auto_clr_dly = 16'($urandom_range(0, 12));
      sync_err_reset = ($urandom_range(0, 199) == 0);
      ttc_resync = ($urandom_range(0, 199) == 0);
      tick();
    end
    sync_err_reset = 0; ttc_resync = 0; err_src = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
